// File: rtl/ntt_pkg.sv
// Shared state encoding and width helpers for the NTT stage controller.
// DEFAULT_RING_SIZE is the ring size used when a module does not override it.
package ntt_pkg;

    localparam int DEFAULT_RING_SIZE = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_A,
        S_RUN_B,
        S_DRAIN,
        S_SCALE,
        S_DONE
    } ctrl_state_t;

    function automatic int f_log_n(input int ring_size);
        return $clog2(ring_size);
    endfunction

    function automatic int f_aw(input int ring_size);
        return f_log_n(ring_size);
    endfunction

    // One spare bit so the group counter cannot wrap even when G == 1.
    function automatic int f_gw(input int ring_size, input int lanes);
        return $clog2(ring_size / (2 * lanes)) + 1;
    endfunction

    function automatic int f_sw(input int ring_size);
        return $clog2(f_log_n(ring_size) + 1);
    endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Lane-0 butterfly operand and twiddle addresses for one group of one stage.
// Purely combinational so it can be exercised on its own.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int RING_SIZE = DEFAULT_RING_SIZE,
    localparam int LOG_N = f_log_n(RING_SIZE),
    localparam int AW = f_aw(RING_SIZE),
    localparam int SW = f_sw(RING_SIZE)
) (
    input  logic [AW-1:0] i_b,
    input  logic [SW-1:0] i_stage,
    input  logic          i_inv,
    output logic [AW-1:0] o_addr_top,
    output logic [AW-1:0] o_addr_bot,
    output logic [AW-1:0] o_tw_addr
);

    logic [AW-1:0] w_half;
    logic [AW-1:0] w_low;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_tw;
    logic [SW-1:0] w_tw_shift;

    // Inverse twiddle is (N - tw) mod N, which is plain negation in AW bits.
    always_comb begin
        w_half     = AW'(1) << i_stage;
        w_low      = i_b & (w_half - AW'(1));
        w_top      = ((i_b >> i_stage) << (i_stage + SW'(1))) | w_low;
        w_tw_shift = SW'(LOG_N - 1) - i_stage;
        w_tw       = w_low << w_tw_shift;
        o_addr_top = w_top;
        o_addr_bot = w_top + w_half;
        o_tw_addr  = i_inv ? (AW'(0) - w_tw) : w_tw;
    end

endmodule

// File: rtl/ntt_stage_controller.sv
// Sequencer for the in-place radix-2 NTT: load, per-stage butterfly groups with
// pipeline drain, optional inverse scaling pass, and a start/busy/done handshake.
module ntt_stage_controller
    import ntt_pkg::*;
#(
    parameter int RING_SIZE = DEFAULT_RING_SIZE,
    parameter int LANES = 1,
    parameter int PIPE_DELAY = 11,
    localparam int LOG_N = f_log_n(RING_SIZE),
    localparam int AW = f_aw(RING_SIZE),
    localparam int GW = f_gw(RING_SIZE, LANES),
    localparam int SW = f_sw(RING_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          inv,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          inv_mode,
    output logic          sel_a,
    output logic          sel_b,
    output logic          sel_ram,
    output logic          scale_en,
    output logic [SW-1:0] stage,
    output logic [AW-1:0] addr_top,
    output logic [AW-1:0] addr_bot,
    output logic [AW-1:0] tw_addr,
    output logic [AW-1:0] load_addr
);

    localparam int CYCLES  = RING_SIZE / LANES;
    localparam int GROUPS  = RING_SIZE / (2 * LANES);
    localparam int CW      = $clog2(CYCLES) + 1;
    localparam int DW      = $clog2(PIPE_DELAY + 1);
    localparam int LANE_SH = $clog2(LANES);

    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(PIPE_DELAY - 1);
    localparam logic [SW-1:0] STG_LAST = SW'(LOG_N - 1);

    ctrl_state_t   r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [GW-1:0] r_group, w_group_next;
    logic [DW-1:0] r_drain, w_drain_next;
    logic [SW-1:0] r_stage, w_stage_next;
    logic          r_inv, w_inv_next;
    logic          w_run;
    logic [AW-1:0] w_b;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_bot;
    logic [AW-1:0] w_tw;

    assign w_b = AW'(r_group) << LANE_SH;

    ntt_addr_gen #(
        .RING_SIZE(RING_SIZE)
    ) u_addr_gen (
        .i_b       (w_b),
        .i_stage   (r_stage),
        .i_inv     (r_inv),
        .o_addr_top(w_top),
        .o_addr_bot(w_bot),
        .o_tw_addr (w_tw)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_group <= '0;
            r_drain <= '0;
            r_stage <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_group <= w_group_next;
            r_drain <= w_drain_next;
            r_stage <= w_stage_next;
            r_inv   <= w_inv_next;
        end
    end

    // hold freezes everything except in IDLE, where only start matters.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_group_next = r_group;
        w_drain_next = r_drain;
        w_stage_next = r_stage;
        w_inv_next   = r_inv;

        if (!(hold && (r_state != S_IDLE))) begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = S_LOAD;
                        w_inv_next   = inv;
                        w_cnt_next   = '0;
                        w_group_next = '0;
                        w_drain_next = '0;
                        w_stage_next = '0;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = S_RUN_A;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                S_RUN_A: w_state_next = S_RUN_B;
                S_RUN_B: begin
                    if (r_group == GRP_LAST) begin
                        w_state_next = S_DRAIN;
                        w_group_next = '0;
                    end else begin
                        w_state_next = S_RUN_A;
                        w_group_next = r_group + GW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRN_LAST) begin
                        w_drain_next = '0;
                        if (r_stage == STG_LAST) begin
                            w_state_next = r_inv ? S_SCALE : S_DONE;
                        end else begin
                            w_state_next = S_RUN_A;
                            w_stage_next = r_stage + SW'(1);
                        end
                    end else begin
                        w_drain_next = r_drain + DW'(1);
                    end
                end
                S_SCALE: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = S_DONE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Addresses are only meaningful while butterflies are issued; zero elsewhere.
    always_comb begin
        w_run     = (r_state == S_RUN_A) || (r_state == S_RUN_B);
        busy      = (r_state != S_IDLE) && (r_state != S_DONE);
        done      = (r_state == S_DONE);
        inv_mode  = r_inv;
        sel_a     = (r_state != S_RUN_B);
        sel_b     = (r_state != S_RUN_A);
        sel_ram   = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);
        scale_en  = (r_state == S_SCALE);
        stage     = r_stage;
        addr_top  = w_run ? w_top : '0;
        addr_bot  = w_run ? w_bot : '0;
        tw_addr   = w_run ? w_tw : '0;
        load_addr = ((r_state == S_LOAD) || (r_state == S_SCALE)) ? (AW'(r_cnt) << LANE_SH) : '0;
    end

endmodule

// File: tb/tb_ntt_stage_controller.sv
// Randomised bench for ntt_stage_controller (N=8, PIPE_DELAY=3, LANES 1 and 4)
// against a cycle-schedule model built from the sequencing rules.
module tb_ntt_stage_controller;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int PD   = 3;
    localparam int OW   = 21;

    logic clk = 1'b0;
    logic reset;
    logic start0, inv0, hold0, start1, inv1, hold1;
    logic busy0, done0, invm0, sa0, sb0, sr0, se0;
    logic busy1, done1, invm1, sa1, sb1, sr1, se1;
    logic [1:0] stg0, stg1;
    logic [2:0] top0, bot0, tw0, la0, top1, bot1, tw1, la1;

    int total = 0;
    int bad = 0;
    int doneCyc;
    int heldPre;
    logic [OW-1:0] qv[$];
    logic [OW-1:0] qc[$];
    int capTop[$];
    int capBot[$];
    int capTw[$];
    int stages[$];

    always #5 clk = ~clk;

    ntt_stage_controller #(.RING_SIZE(N), .LANES(1), .PIPE_DELAY(PD)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .inv(inv0), .hold(hold0),
        .busy(busy0), .done(done0), .inv_mode(invm0), .sel_a(sa0), .sel_b(sb0),
        .sel_ram(sr0), .scale_en(se0), .stage(stg0), .addr_top(top0),
        .addr_bot(bot0), .tw_addr(tw0), .load_addr(la0)
    );

    ntt_stage_controller #(.RING_SIZE(N), .LANES(4), .PIPE_DELAY(PD)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .inv(inv1), .hold(hold1),
        .busy(busy1), .done(done1), .inv_mode(invm1), .sel_a(sa1), .sel_b(sb1),
        .sel_ram(sr1), .scale_en(se1), .stage(stg1), .addr_top(top1),
        .addr_bot(bot1), .tw_addr(tw1), .load_addr(la1)
    );

    // Packed layout: busy done inv_mode sel_a sel_b sel_ram scale_en stage[2] top[3] bot[3] tw[3] load[3]
    function automatic logic [OW-1:0] pk(input bit b, input bit d, input bit im, input bit sa,
                                         input bit sb, input bit sr, input bit se, input int st,
                                         input int tp, input int bt, input int tw, input int la);
        logic [1:0] s2;
        logic [2:0] t3, b3, w3, l3;
        s2 = st[1:0];
        t3 = tp[2:0];
        b3 = bt[2:0];
        w3 = tw[2:0];
        l3 = la[2:0];
        return {b, d, im, sa, sb, sr, se, s2, t3, b3, w3, l3};
    endfunction

    function automatic logic [OW-1:0] getObs(input int which);
        if (which == 0) return {busy0, done0, invm0, sa0, sb0, sr0, se0, stg0, top0, bot0, tw0, la0};
        return {busy1, done1, invm1, sa1, sb1, sr1, se1, stg1, top1, bot1, tw1, la1};
    endfunction

    function automatic int latency(input int lanes, input bit iv);
        return N / lanes + LOGN * (2 * (N / (2 * lanes)) + PD) + (iv ? N / lanes : 0) + 1;
    endfunction

    // Expected output of every non-held cycle from start acceptance to DONE.
    function automatic void build(input bit iv, input int lanes);
        int g, b, h, top, tw;
        logic [OW-1:0] cLoad, cRun, cDrain, cDone;
        qv.delete();
        qc.delete();
        g      = N / (2 * lanes);
        cLoad  = pk(1, 1, 1, 0, 0, 1, 1, 3, 0, 0, 0, 7);
        cRun   = pk(1, 1, 1, 1, 1, 1, 1, 3, 7, 7, 7, 0);
        cDrain = pk(1, 1, 1, 1, 1, 1, 1, 3, 0, 0, 0, 0);
        cDone  = pk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int c = 0; c < N / lanes; c++) begin
            qv.push_back(pk(1, 0, iv, 1, 1, 1, 0, 0, 0, 0, 0, c * lanes));
            qc.push_back(cLoad);
        end
        for (int s = 0; s < LOGN; s++) begin
            h = 1 << s;
            for (int gg = 0; gg < g; gg++) begin
                b   = gg * lanes;
                top = (b / h) * 2 * h + b % h;
                tw  = (b % h) * (N / (2 * h));
                if (iv) tw = (N - tw) % N;
                qv.push_back(pk(1, 0, iv, 1, 0, 0, 0, s, top, top + h, tw, 0));
                qc.push_back(cRun);
                qv.push_back(pk(1, 0, iv, 0, 1, 0, 0, s, top, top + h, tw, 0));
                qc.push_back(cRun);
            end
            for (int d = 0; d < PD; d++) begin
                qv.push_back(pk(1, 0, iv, 1, 1, 0, 0, s, 0, 0, 0, 0));
                qc.push_back(cDrain);
            end
        end
        if (iv) begin
            for (int c = 0; c < N / lanes; c++) begin
                qv.push_back(pk(1, 0, iv, 1, 1, 0, 1, LOGN - 1, 0, 0, 0, c * lanes));
                qc.push_back(cLoad);
            end
        end
        qv.push_back(pk(0, 1, iv, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        qc.push_back(cDone);
    endfunction

    task automatic drive(input int which, input bit s, input bit i, input bit h);
        if (which == 0) begin
            start0 = s; inv0 = i; hold0 = h;
        end else begin
            start1 = s; inv1 = i; hold1 = h;
        end
    endtask

    task automatic checkIdle(input int which, input bit iv, input string name);
        logic [OW-1:0] obs, ev, care;
        obs  = getObs(which);
        ev   = pk(0, 0, iv, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        care = pk(1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        total++;
        if ((obs & care) !== (ev & care)) begin
            bad++;
            $display("[TB] FAIL %s dut=%0d got=%h want=%h care=%h", name, which, obs, ev, care);
        end
    endtask

    // One full run: hold is random (holdPct) or forced over [holdFrom, holdFrom+holdLen);
    // with poke set, start and inv toggle randomly while busy and must be ignored.
    task automatic runSeq(input int which, input bit iv, input int holdPct,
                          input int holdFrom, input int holdLen, input bit poke);
        int idx, cyc;
        bit h, s, i;
        logic [OW-1:0] obs;
        build(iv, (which == 0) ? 1 : 4);
        capTop.delete(); capBot.delete(); capTw.delete(); stages.delete();
        doneCyc = -1;
        heldPre = 0;
        @(negedge clk);
        drive(which, 1'b1, iv, 1'b0);
        @(posedge clk);
        #1;
        idx = 0;
        cyc = 1;
        while (1) begin
            obs = getObs(which);
            total++;
            if ((obs & qc[idx]) !== (qv[idx] & qc[idx])) begin
                bad++;
                $display("[TB] FAIL cycle dut=%0d cyc=%0d step=%0d got=%h want=%h care=%h",
                         which, cyc, idx, obs, qv[idx], qc[idx]);
            end
            if (obs[19] === 1'b1 && doneCyc < 0) doneCyc = cyc;
            if (obs[20] === 1'b1 && (stages.size() == 0 || stages[$] != int'(obs[13:12])))
                stages.push_back(int'(obs[13:12]));
            if (obs[17] === 1'b1 && obs[16] === 1'b0 && obs[13:12] === 2'd1) begin
                capTop.push_back(int'(obs[11:9]));
                capBot.push_back(int'(obs[8:6]));
                capTw.push_back(int'(obs[5:3]));
            end
            @(negedge clk);
            h = ((holdPct > 0) && ($urandom_range(99) < holdPct)) ||
                ((cyc >= holdFrom) && (cyc < holdFrom + holdLen));
            s = poke && ($urandom_range(1) == 1);
            i = poke ? ($urandom_range(1) == 1) : iv;
            drive(which, s, i, h);
            @(posedge clk);
            #1;
            cyc++;
            if (h) begin
                if (doneCyc < 0) heldPre++;
            end else begin
                idx++;
            end
            if (idx >= qv.size()) break;
            if (cyc > 4000) begin
                total++;
                bad++;
                $display("[TB] FAIL timeout dut=%0d got=step %0d want=step %0d", which, idx, qv.size());
                break;
            end
        end
        checkIdle(which, iv, "idle_after_done");
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkIdle(which, iv, "no_second_run");
    endtask

    task automatic checkDoneAt(input int want, input string name);
        total++;
        if (doneCyc !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, doneCyc, want);
        end
    endtask

    task automatic checkReset(input int which, input string name);
        logic [OW-1:0] obs, ev;
        obs = getObs(which);
        ev  = pk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== ev) begin
            bad++;
            $display("[TB] FAIL %s dut=%0d got=%h want=%h", name, which, obs, ev);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkReset(0, "reset_state");
        checkReset(1, "reset_state");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_forward();
        int wantTw[4] = '{0, 2, 0, 2};
        int wantTop[4] = '{0, 1, 4, 5};
        runSeq(0, 1'b0, 0, -1, 0, 1'b0);
        checkDoneAt(latency(1, 1'b0), "fwd_done_edge");
        checkDoneAt(42, "fwd_done_42");
        total++;
        if (stages.size() != 3 || stages[0] != 0 || stages[1] != 1 || stages[2] != 2) begin
            bad++;
            $display("[TB] FAIL stage_seq got=%p want=0,1,2", stages);
        end
        total++;
        if (capTop.size() != 4) begin
            bad++;
            $display("[TB] FAIL stage1_count got=%0d want=4", capTop.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (capTop[k] != wantTop[k] || capBot[k] != wantTop[k] + 2 || capTw[k] != wantTw[k]) begin
                    bad++;
                    $display("[TB] FAIL stage1_addr k=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                             k, capTop[k], capBot[k], capTw[k], wantTop[k], wantTop[k] + 2, wantTw[k]);
                end
            end
        end
    endtask

    task automatic test_inverse();
        int wantTw[4] = '{0, 6, 0, 6};
        runSeq(0, 1'b1, 0, -1, 0, 1'b0);
        checkDoneAt(50, "inv_done_50");
        total++;
        if (capTw.size() != 4) begin
            bad++;
            $display("[TB] FAIL inv_stage1_count got=%0d want=4", capTw.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (capTw[k] != wantTw[k]) begin
                    bad++;
                    $display("[TB] FAIL inv_tw k=%0d got=%0d want=%0d", k, capTw[k], wantTw[k]);
                end
            end
        end
    endtask

    task automatic test_lanes4();
        runSeq(1, 1'b0, 0, -1, 0, 1'b0);
        checkDoneAt(18, "lanes4_done_18");
        runSeq(1, 1'b1, 0, -1, 0, 1'b0);
        checkDoneAt(latency(4, 1'b1), "lanes4_inv_done");
    endtask

    task automatic test_hold();
        runSeq(0, 1'b0, 0, 17, 5, 1'b1);
        checkDoneAt(47, "hold_done_47");
    endtask

    task automatic test_reset_abort();
        logic [OW-1:0] obs;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        repeat (20) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        obs = getObs(0);
        total++;
        if (obs[17] !== 1'b0 || obs[16] !== 1'b1 || obs[13:12] !== 2'd1) begin
            bad++;
            $display("[TB] FAIL abort_point got=sa%b sb%b st%0d want=sa0 sb1 st1", obs[17], obs[16], obs[13:12]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkReset(0, "abort_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            total++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_quiet got=done%b busy%b want=done0 busy0", done0, busy0);
            end
        end
        runSeq(0, 1'b0, 0, -1, 0, 1'b0);
        checkDoneAt(42, "after_abort_done");
    endtask

    task automatic test_random();
        int which;
        bit iv;
        for (int r = 0; r < 8; r++) begin
            which = $urandom_range(1);
            iv = ($urandom_range(1) == 1);
            runSeq(which, iv, 30, -1, 0, 1'b1);
            checkDoneAt(latency((which == 0) ? 1 : 4, iv) + heldPre, "random_done");
        end
    endtask

    task automatic test_back_to_back();
        runSeq(0, 1'b1, 0, -1, 0, 1'b0);
        checkDoneAt(50, "b2b_first");
        runSeq(0, 1'b0, 0, -1, 0, 1'b0);
        checkDoneAt(42, "b2b_second");
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        test_reset();
        test_forward();
        test_inverse();
        test_lanes4();
        test_hold();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
